vga_vertical_timing: RTL and testbench
======================================

VGA_VERTICAL_TIMING -- requirements
Module: vga_vertical_timing

Interface
REQ-001 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-002 SHALL have parameter V_FP, default 10: front-porch lines.
REQ-003 SHALL have parameter V_SYNC, default 2: sync-pulse lines.
REQ-004 SHALL have parameter V_BP, default 33: back-porch lines; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP SHALL be at most 1024.
REQ-005 SHALL have parameter SYNC_POL, default 0: vsync asserted level.
REQ-006 SHALL have port clock, input, 1: single clock; one clock, all state on rising edge.
REQ-007 SHALL have port res, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port line_end, input, 1: one-cycle pulse from the horizontal counter on the last pixel clock of each line.
REQ-009 SHALL have port vcount, output, 10: current line number, 0..V_TOTAL-1.
REQ-010 SHALL have port vsync, output, 1: vertical sync, level per SYNC_POL.
REQ-011 SHALL have port vblank, output, 1: high outside the active region.
REQ-012 SHALL have port frame_start, output, 1: one-cycle pulse when vcount wraps to 0.
REQ-013 SHALL have port frame_count, output, 16: completed-frame count; present only under FRAME_COUNT_EN.

Function
REQ-014 SHALL use a registered FSM with states ACTIVE, FRONT, SYNC and BACK, advancing only on cycles where line_end=1.
REQ-015 SHALL, on line_end=1, update vcount to vcount+1 in the next cycle (latency 1); vcount=V_TOTAL-1 SHALL wrap to 0.
REQ-016 SHALL make these transitions, evaluated on the new vcount: ACTIVE->FRONT at V_ACTIVE; FRONT->SYNC at V_ACTIVE+V_FP; SYNC->BACK at V_ACTIVE+V_FP+V_SYNC; BACK->ACTIVE on wrap to 0.
REQ-017 SHALL assert vsync=SYNC_POL exactly while state=SYNC, and drive ~SYNC_POL otherwise.
REQ-018 SHALL hold vblank=1 exactly while state is not ACTIVE.
REQ-019 SHALL keep all outputs registered and changing in the same cycle as vcount.
REQ-020 SHALL pulse frame_start high for exactly one cycle, the cycle in which vcount becomes 0 through a wrap.
REQ-021 SHALL treat line_end held high for N consecutive cycles as N lines, with no edge detection.
REQ-022 SHALL hold all state unchanged while line_end=0, with no drift.
REQ-023 SHALL, in any zero-length phase (e.g. V_FP=0), skip that state so that the state always matches the vcount range.

Reset
REQ-024 SHALL give res priority over line_end when both are high in the same cycle.
REQ-025 SHALL, one cycle after res=1, set vcount=0, state=ACTIVE, vsync=~SYNC_POL, vblank=0, frame_start=0 and frame_count=0.
REQ-026 SHALL restart the frame from line 0 on reset mid-frame, with no frame_start pulse generated by the reset itself.

Configuration
REQ-027 SHALL, with macro VGA_FRAME_COUNT_EN defined, include port frame_count, which increments by 1 in the same cycle frame_start pulses and wraps 65535->0.
REQ-028 SHALL, without VGA_FRAME_COUNT_EN, omit the frame_count port and its register, with all other behaviour identical.

Verification
REQ-029 SHALL cover: res=1 for 2 cycles, then 0 -> vcount=0, vblank=0, vsync=1 (SYNC_POL=0), frame_start=0.
REQ-030 SHALL cover: 480 line_end pulses -> vcount=480, vblank=1, vsync=1; 490 pulses -> vsync=0; 492 pulses -> vsync=1.
REQ-031 SHALL cover: 525 pulses -> vcount=0, frame_start high for exactly 1 cycle, vblank=0; frame_count=1 if VGA_FRAME_COUNT_EN.
REQ-032 SHALL cover: line_end held high for 3 cycles starting from vcount=10 -> vcount=13.
REQ-033 SHALL cover: res=1 and line_end=1 in the same cycle at vcount=491 -> vcount=0, vsync=1, no frame_start.
REQ-034 SHALL cover: V_FP=0 build, 480 pulses -> state=SYNC with vsync=0 and vblank=1 directly.

Source files
------------

// File: rtl/vga_vertical_timing.sv
// Vertical VGA timing: line counter plus ACTIVE/FRONT/SYNC/BACK phase FSM advanced by line_end.
// Optional frame_count port and counter are enabled by defining VGA_FRAME_COUNT_EN.
module vga_vertical_timing #(
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clock,
    input  logic        res,
    input  logic        line_end,
    output logic [9:0]  vcount,
    output logic        vsync,
    output logic        vblank,
    output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int unsigned VW      = 10;
    localparam int unsigned CW      = VW + 1;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [VW-1:0] LAST_LINE = VW'(V_TOTAL - 1);
    localparam logic [CW-1:0] ACT_END   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] FP_END    = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] SYNC_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic          vsync_q, vsync_d;
    logic          vblank_q, vblank_d;
    logic          frame_start_q, frame_start_d;
    logic          wrap_c;

    // Phase owning a given line; empty phases never match, so they are skipped.
    function automatic state_e phase_of(input logic [VW-1:0] line);
        logic [CW-1:0] l;
        l = {1'b0, line};
        if (l < ACT_END)       return ACTIVE;
        else if (l < FP_END)   return FRONT;
        else if (l < SYNC_END) return SYNC;
        else                   return BACK;
    endfunction

    assign wrap_c = (vcount_q == LAST_LINE);

    // Next-state and registered-output decode, evaluated on the new line number.
    always_comb begin
        vcount_d      = vcount_q;
        state_d       = state_q;
        frame_start_d = 1'b0;
        if (line_end) begin
            vcount_d      = wrap_c ? '0 : vcount_q + VW'(1);
            state_d       = phase_of(vcount_d);
            frame_start_d = wrap_c;
        end
        vsync_d  = (state_d == SYNC) ? SYNC_POL : ~SYNC_POL;
        vblank_d = (state_d != ACTIVE);
    end

    always_ff @(posedge clock) begin
        if (res) begin
            state_q       <= ACTIVE;
            vcount_q      <= '0;
            vsync_q       <= ~SYNC_POL;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vcount_q      <= vcount_d;
            vsync_q       <= vsync_d;
            vblank_q      <= vblank_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    localparam int unsigned FCW = 16;
    logic [FCW-1:0] frame_count_q, frame_count_d;

    // Completed frames, bumped alongside frame_start and wrapping naturally.
    always_comb begin
        frame_count_d = frame_count_q;
        if (frame_start_d) frame_count_d = frame_count_q + FCW'(1);
    end

    always_ff @(posedge clock) begin
        if (res) frame_count_q <= '0;
        else     frame_count_q <= frame_count_d;
    end

    assign frame_count = frame_count_q;
`endif

    assign vcount      = vcount_q;
    assign vsync       = vsync_q;
    assign vblank      = vblank_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_vertical_timing.sv
// Bench for vga_vertical_timing: default timing and a V_FP=0 variant driven in lockstep,
// compared every cycle against a line-number reference model.
module tb_vga_vertical_timing;

    logic clock = 1'b0;
    logic res = 1'b0;
    logic line_end = 1'b0;

    logic [9:0] vc_a, vc_b;
    logic       vs_a, vs_b, vb_a, vb_b, fs_a, fs_b;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] fc_a, fc_b;
`endif

    int checks = 0;
    int errors = 0;

    // Model state per instance: 0 = default timing, 1 = V_FP=0
    int tot[2]   = '{525, 515};
    int act[2]   = '{480, 480};
    int fp[2]    = '{10, 0};
    int syn[2]   = '{2, 2};
    int line[2]  = '{0, 0};
    int fsm[2]   = '{0, 0};
    int frames[2] = '{0, 0};

    always #5 clock = ~clock;

    vga_vertical_timing u_dut_a (
        .clock      (clock),
        .res        (res),
        .line_end   (line_end),
        .vcount     (vc_a),
        .vsync      (vs_a),
        .vblank     (vb_a),
        .frame_start(fs_a)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_count(fc_a)
`endif
    );

    vga_vertical_timing #(.V_FP(0)) u_dut_b (
        .clock      (clock),
        .res        (res),
        .line_end   (line_end),
        .vcount     (vc_b),
        .vsync      (vs_b),
        .vblank     (vb_b),
        .frame_start(fs_b)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_count(fc_b)
`endif
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int ev_sync;
            int ev_blank;
            ev_sync  = (line[i] >= act[i] + fp[i] && line[i] < act[i] + fp[i] + syn[i]) ? 0 : 1;
            ev_blank = (line[i] >= act[i]) ? 1 : 0;
            check($sformatf("vcount[%0d]", i), int'(i == 0 ? vc_a : vc_b), line[i]);
            check($sformatf("vsync[%0d]", i), int'(i == 0 ? vs_a : vs_b), ev_sync);
            check($sformatf("vblank[%0d]", i), int'(i == 0 ? vb_a : vb_b), ev_blank);
            check($sformatf("frame_start[%0d]", i), int'(i == 0 ? fs_a : fs_b), fsm[i]);
`ifdef VGA_FRAME_COUNT_EN
            check($sformatf("frame_count[%0d]", i), int'(i == 0 ? fc_a : fc_b), frames[i]);
`endif
        end
    endtask

    // One clock: drive on the falling edge, advance the model, sample 1 ns after the rising edge.
    task automatic step(input logic le, input logic rs);
        @(negedge clock);
        line_end = le;
        res      = rs;
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rs) begin
                line[i] = 0; fsm[i] = 0; frames[i] = 0;
            end else if (le) begin
                fsm[i]  = (line[i] == tot[i] - 1) ? 1 : 0;
                line[i] = (line[i] + 1) % tot[i];
                if (fsm[i] == 1) frames[i] = (frames[i] + 1) % 65536;
            end else begin
                fsm[i] = 0;
            end
        end
        compare_all();
    endtask

    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0);
    endtask

    initial begin
        // Reset for two cycles
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("rst_vcount", int'(vc_a), 0);
        check("rst_vsync", int'(vs_a), 1);
        check("rst_vblank", int'(vb_a), 0);
        check("rst_frame_start", int'(fs_a), 0);

        // Walk one full frame on back-to-back pulses
        pulses(480);
        check("l480_vcount", int'(vc_a), 480);
        check("l480_vblank", int'(vb_a), 1);
        check("l480_vsync", int'(vs_a), 1);
        check("fp0_l480_vsync", int'(vs_b), 0);
        check("fp0_l480_vblank", int'(vb_b), 1);
        pulses(10);
        check("l490_vsync", int'(vs_a), 0);
        pulses(2);
        check("l492_vsync", int'(vs_a), 1);
        pulses(33);
        check("wrap_vcount", int'(vc_a), 0);
        check("wrap_frame_start", int'(fs_a), 1);
        check("wrap_vblank", int'(vb_a), 0);
        step(1'b0, 1'b0);
        check("wrap_fs_one_cycle", int'(fs_a), 0);

        // Idle cycles: nothing may drift
        repeat (20) step(1'b0, 1'b0);

        // Randomized line_end traffic with occasional mid-frame resets
        for (int k = 0; k < 2500; k++) begin
            logic le, rs;
            le = 1'($urandom_range(0, 3) != 0);
            rs = 1'($urandom_range(0, 599) == 0);
            step(le, rs);
        end

        // line_end held for three consecutive cycles from line 10
        step(1'b0, 1'b1);
        pulses(10);
        check("hold_start_vcount", int'(vc_a), 10);
        pulses(3);
        check("hold_end_vcount", int'(vc_a), 13);

        // Reset wins over line_end during the sync pulse
        step(1'b0, 1'b1);
        pulses(491);
        check("pre_rst_vsync", int'(vs_a), 0);
        step(1'b1, 1'b1);
        check("rst_mid_vcount", int'(vc_a), 0);
        check("rst_mid_vsync", int'(vs_a), 1);
        check("rst_mid_frame_start", int'(fs_a), 0);
        step(1'b0, 1'b0);
        check("rst_mid_no_fs", int'(fs_a), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
